block_data_memory: RTL and testbench

//   Word-organised main data memory: the responder end of the cache<->memory busywait interface.

---
 rtl/dmem_pkg.sv | 7 +
 rtl/block_data_memory_array.sv | 26 ++
 rtl/block_data_memory.sv | 76 +++++++
 tb/tb_block_data_memory.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding and default geometry/latency for the block data memory.
package dmem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, ACK = 2'd2} state_t;
  localparam int DEF_ADDR_W  = 6;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_LATENCY = 5;
endpackage

// File: rtl/block_data_memory_array.sv
// dmem_array: DEPTH x DATA_W storage, sync write, registered read port, async clear of every word.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/block_data_memory.sv
// block_data_memory: busywait-handshake main memory with a counted access latency.
// Optional read/write completion counters when DMEM_STATS_EN is defined.
module block_data_memory
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              busywait
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);
  localparam logic [3:0] LAST = 4'(LATENCY - 1);
  state_t state, state_next;
  logic [3:0] counter;
  logic op_write;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic done;
  assign done = (state == ACCESS) && (counter == LAST);
  always_comb begin
    state_next = (state == IDLE)   ? ((read | write) ? ACCESS : IDLE) :
                 (state == ACCESS) ? (done ? ACK : ACCESS) : IDLE;
    busywait   = (state == IDLE) ? (read | write) : (state == ACCESS);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      counter  <= '0;
      op_write <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && (read | write)) begin
        op_write <= write;
        addr_q   <= address;
        wdata_q  <= writedata;
        counter  <= '0;
      end else if (state == ACCESS) begin
        counter <= counter + 4'd1;
      end
    end
  end
  dmem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
    .clock (clock),
    .reset (reset),
    .we    (done & op_write),
    .re    (done & ~op_write),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (readdata)
  );
`ifdef DMEM_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (done) begin
      if (!op_write && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      if (op_write && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_block_data_memory.sv
// tb_block_data_memory: randomized self-checking bench against an array model of the memory.
module tb_block_data_memory;
  localparam int LAT = 5;
  logic clock = 1'b0, reset = 1'b0, read = 1'b0, write = 1'b0;
  logic [5:0] address = '0;
  logic [31:0] writedata = '0, readdata;
  logic busywait;
  int vectors = 0, miscompares = 0;
  logic [31:0] mem_m [64];
  logic [31:0] exp_rd = '0;
  int rd_n = 0, wr_n = 0;
`ifdef DMEM_STATS_EN
  logic [15:0] rd_count, wr_count;
`endif
  block_data_memory #(.ADDR_W(6), .DATA_W(32), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .read(read), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata), .busywait(busywait)
`ifdef DMEM_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );
  always #5 clock = ~clock;
  task automatic model_clear();
    for (int i = 0; i < 64; i++) mem_m[i] = '0;
    exp_rd = '0;
    rd_n = 0;
    wr_n = 0;
  endtask
  // Called at a negedge with the DUT idle; returns at the negedge after ACK with inputs dropped.
  task automatic do_req(input logic rd, input logic wr, input logic [5:0] a, input logic [31:0] d,
                        input bit scramble, output int busy, output logic [31:0] rdat);
    read = rd; write = wr; address = a; writedata = d;
    busy = 0;
    forever begin
      #1;
      if (!busywait) break;
      busy++;
      if (busy > 40) begin
        vectors++; miscompares++;
        $display("FAIL busywait_timeout: busywait still high after %0d cycles, required %0d", busy, LAT + 1);
        break;
      end
      @(negedge clock);
      if (scramble) begin
        address = 6'($urandom);
        writedata = $urandom;
      end
    end
    rdat = readdata;
    read = 1'b0; write = 1'b0;
    @(negedge clock);
  endtask
  task automatic access(input logic rd, input logic wr, input logic [5:0] a, input logic [31:0] d,
                        input bit scramble);
    int busy;
    logic [31:0] rdat;
    do_req(rd, wr, a, d, scramble, busy, rdat);
    if (wr) begin mem_m[a] = d; wr_n++; end
    else if (rd) begin exp_rd = mem_m[a]; rd_n++; end
    vectors++;
    if (busy !== LAT + 1) begin
      miscompares++;
      $display("FAIL busy_cycles: addr=%h rd=%b wr=%b got %0d required %0d", a, rd, wr, busy, LAT + 1);
    end
    vectors++;
    if (rdat !== exp_rd) begin
      miscompares++;
      $display("FAIL readdata: addr=%h rd=%b wr=%b got %h required %h", a, rd, wr, rdat, exp_rd);
    end
  endtask
  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    model_clear();
    vectors++;
    if (busywait !== 1'b0 || readdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: busywait=%b readdata=%h required 0/00000000", busywait, readdata);
    end
    @(negedge clock);
    reset = 1'b0;
    access(1'b1, 1'b0, 6'h00, 32'h0, 1'b0);
  endtask
  task automatic test_write_read();
    access(1'b0, 1'b1, 6'h2A, 32'hDEADBEEF, 1'b0);
    access(1'b1, 1'b0, 6'h2A, 32'h0, 1'b0);
  endtask
  task automatic test_back_to_back();
    access(1'b0, 1'b1, 6'h0D, 32'h0BADF00D, 1'b0);
    access(1'b0, 1'b1, 6'h05, 32'h55AA55AA, 1'b0);
    access(1'b1, 1'b0, 6'h0D, 32'h0, 1'b0);
  endtask
  task automatic test_read_write_both();
    access(1'b1, 1'b1, 6'h10, 32'h12345678, 1'b0);
    access(1'b1, 1'b0, 6'h10, 32'h0, 1'b0);
  endtask
  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic rd, wr;
      rd = 1'($urandom);
      wr = ~rd | 1'($urandom_range(0, 7) == 0);
      access(rd, wr, 6'($urandom_range(0, 15)), $urandom, 1'b1);
    end
  endtask
  task automatic test_reset_mid_access();
    read = 1'b0; write = 1'b1; address = 6'h01; writedata = 32'hCAFEF00D;
    repeat (3) @(negedge clock);
    reset = 1'b1; write = 1'b0;
    #1;
    model_clear();
    vectors++;
    if (busywait !== 1'b0 || readdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid_access: busywait=%b readdata=%h required 0/00000000", busywait, readdata);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (8) @(negedge clock);
    vectors++;
    if (busywait !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: busywait got %b required 0", busywait);
    end
    access(1'b1, 1'b0, 6'h01, 32'h0, 1'b0);
  endtask
`ifdef DMEM_STATS_EN
  task automatic test_stats();
    for (int i = 0; i < 3; i++) access(1'b0, 1'b1, 6'(i + 32), $urandom, 1'b0);
    for (int i = 0; i < 2; i++) access(1'b1, 1'b0, 6'(i + 32), 32'h0, 1'b0);
    vectors++;
    if (rd_count !== 16'(rd_n) || wr_count !== 16'(wr_n)) begin
      miscompares++;
      $display("FAIL stats: rd_count=%0d wr_count=%0d required %0d/%0d", rd_count, wr_count, rd_n, wr_n);
    end
  endtask
`endif
  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_read_write_both();
    test_random();
    test_reset_mid_access();
`ifdef DMEM_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
